// File: rtl/write_buffer.sv
// Posted-write FIFO between the cache RAM-side port and external RAM.
// Writes are acked at once and drained in the background; reads bypass queued writes unless they hit one.
module write_buffer #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] up_address,
   input  logic                     up_rd,
   input  logic                     up_wr,
   input  logic [3:0]               up_byte_enable,
   input  logic [31:0]              up_data_wr,
   output logic [31:0]              up_data_rd,
   output logic                     up_ready,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic [3:0]               mem_byte_enable,
   output logic [31:0]              mem_data_wr,
   input  logic [31:0]              mem_data_rd,
   input  logic                     mem_ready,
   output logic                     buffer_empty
);

   localparam int WW = ADDRESS_WIDTH - 2;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} m_state_t;

   m_state_t                 state, state_next;
   logic [WW-1:0]            q_addr [DEPTH];
   logic [31:0]              q_data [DEPTH];
   logic [3:0]               q_be   [DEPTH];
   logic [DEPTH-1:0]         q_valid;
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [CW-1:0]            count, count_next;
   logic [ADDRESS_WIDTH-1:0] rd_address;
   logic                     enq, pop, read_done, hazard, start_read;

   assign enq       = up_wr & ~up_ready & (count < CW'(DEPTH));
   assign pop       = (state == M_WRITE) & mem_ready;
   assign read_done = (state == M_READ) & mem_ready;

   // A read is a hazard if its word matches any still-queued write.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (q_valid[i] && q_addr[i] == up_address[ADDRESS_WIDTH-1:2])
            hazard = 1'b1;
   end

   always_comb begin
      count_next = count;
      if (enq && !pop)
         count_next = count + 1'b1;
      else if (pop && !enq)
         count_next = count - 1'b1;
   end

   // NOTE: the entry storage has no reset; q_valid and count alone say which entries are live.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_addr[wr_ptr] <= up_address[ADDRESS_WIDTH-1:2];
         q_data[wr_ptr] <= up_data_wr;
         q_be[wr_ptr]   <= up_byte_enable;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         buffer_empty <= 1'b1;
      end else begin
         if (pop) begin
            q_valid[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         if (enq) begin
            q_valid[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         count        <= count_next;
         buffer_empty <= (count_next == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= M_IDLE;
      else
         state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_next      = state;
      start_read      = 1'b0;
      mem_rd          = 1'b0;
      mem_wr          = 1'b0;
      mem_address     = '0;
      mem_byte_enable = '0;
      mem_data_wr     = '0;
      case (state)
         M_IDLE: begin
            if (up_rd && !up_ready && !hazard) begin
               start_read = 1'b1;
               state_next = M_READ;
            end else if (count != '0) begin
               state_next = M_WRITE;
            end
         end
         M_WRITE: begin
            mem_wr          = 1'b1;
            mem_address     = {q_addr[rd_ptr], 2'b00};
            mem_byte_enable = q_be[rd_ptr];
            mem_data_wr     = q_data[rd_ptr];
            if (mem_ready) state_next = M_IDLE;
         end
         M_READ: begin
            mem_rd          = 1'b1;
            mem_address     = rd_address;
            mem_byte_enable = 4'hF;
            if (mem_ready) state_next = M_IDLE;
         end
         default: state_next = M_IDLE;
      endcase
   end

   // Returning to M_IDLE after every transaction keeps a stale mem_ready from being seen as a completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_ready   <= 1'b0;
         up_data_rd <= '0;
         rd_address <= '0;
      end else begin
         up_ready <= enq | read_done;
         if (read_done)  up_data_rd <= mem_data_rd;
         if (start_read) rd_address <= up_address;
      end
   end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: RAM model with word i = i and adjustable mem_ready latency/hold.
module tb_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] up_address;
   logic        up_rd, up_wr;
   logic [3:0]  up_byte_enable;
   logic [31:0] up_data_wr, up_data_rd;
   logic        up_ready;
   logic [15:0] mem_address;
   logic        mem_rd, mem_wr;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_data_wr, mem_data_rd;
   logic        mem_ready;
   logic        buffer_empty;

   int checks   = 0;
   int failures = 0;

   write_buffer #(.ADDRESS_WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .up_address(up_address), .up_rd(up_rd), .up_wr(up_wr),
      .up_byte_enable(up_byte_enable), .up_data_wr(up_data_wr),
      .up_data_rd(up_data_rd), .up_ready(up_ready),
      .mem_address(mem_address), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_byte_enable(mem_byte_enable), .mem_data_wr(mem_data_wr),
      .mem_data_rd(mem_data_rd), .mem_ready(mem_ready),
      .buffer_empty(buffer_empty)
   );

   always #5 clk = ~clk;

   // RAM model
   logic [31:0] ram [256];
   int          latency = 1;
   bit          hold    = 1'b0;
   int          wait_cnt;
   int          ram_writes = 0;

   initial for (int i = 0; i < 256; i++) ram[i] = i;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ready   <= 1'b0;
         mem_data_rd <= '0;
         wait_cnt    <= 0;
      end else begin
         mem_ready <= 1'b0;
         if ((mem_rd || mem_wr) && !mem_ready && !hold) begin
            if (wait_cnt >= latency - 1) begin
               mem_ready   <= 1'b1;
               wait_cnt    <= 0;
               mem_data_rd <= ram[mem_address[9:2]];
               if (mem_wr) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_byte_enable[b]) ram[mem_address[9:2]][8*b +: 8] <= mem_data_wr[8*b +: 8];
                  ram_writes <= ram_writes + 1;
               end
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   // Bus monitor
   logic [15:0] last_wr_addr = '0;
   int          mem_wr_cycles = 0;
   bit          rd_seen = 1'b0;
   logic        rd_seen_empty = 1'b0;

   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         last_wr_addr  = mem_address;
         mem_wr_cycles = mem_wr_cycles + 1;
      end
      if (mem_rd === 1'b1 && !rd_seen) begin
         rd_seen       = 1'b1;
         rd_seen_empty = buffer_empty;
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic write_req(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be,
                            input int max_cyc, output int cyc, output bit acked);
      up_address = addr; up_data_wr = data; up_byte_enable = be; up_wr = 1'b1;
      acked = 1'b0; cyc = 0;
      while (!acked && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (up_ready === 1'b1) acked = 1'b1;
      end
      up_wr = 1'b0;
   endtask

   task automatic read_req(input logic [15:0] addr, input int max_cyc, output bit acked);
      int cyc;
      up_address = addr; up_rd = 1'b1; rd_seen = 1'b0;
      acked = 1'b0; cyc = 0;
      while (!acked && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (up_ready === 1'b1) acked = 1'b1;
      end
      up_rd = 1'b0;
   endtask

   task automatic wait_empty(input string tag, input int max_cyc);
      int cyc;
      cyc = 0;
      while (buffer_empty !== 1'b1 && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, buffer_empty, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bit ack;
      int w0, wr_before, cyc_before;

      rst = 1'b1; up_address = '0; up_rd = 1'b0; up_wr = 1'b0;
      up_byte_enable = '0; up_data_wr = '0;
      #23;
      check("rst_up_ready",     up_ready, 1'b0);
      check("rst_up_data_rd",   up_data_rd, 32'h0);
      check("rst_mem_rd",       mem_rd, 1'b0);
      check("rst_mem_wr",       mem_wr, 1'b0);
      check("rst_mem_address",  mem_address, 16'h0);
      check("rst_buffer_empty", buffer_empty, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // 1: single posted write
      write_req(16'h003C, 32'hDEADBEEF, 4'hF, 10, cyc, ack);
      check("t1_ack", ack, 1'b1);
      check("t1_ack_latency", cyc, 1);
      wait_empty("t1_drain", 20);
      check("t1_mem_wr_addr", last_wr_addr, 16'h003C);
      check("t1_ram_word15", ram[15], 32'hDEADBEEF);

      // 2: fill with memory stalled
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         write_req(16'h0080 + 16'(4 * i), 32'hA0 + i, 4'hF, 10, cyc, ack);
         check($sformatf("t2_ack%0d", i), ack, 1'b1);
      end
      check("t2_count_full", dut.count, 3'd4);
      w0 = ram_writes;
      up_address = 16'h0090; up_data_wr = 32'hA4; up_byte_enable = 4'hF; up_wr = 1'b1;
      ack = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (up_ready === 1'b1) ack = 1'b1;
      end
      check("t2_fifth_stalled", ack, 1'b0);
      hold = 1'b0;
      cyc = 0;
      while (!ack && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (up_ready === 1'b1) ack = 1'b1;
      end
      up_wr = 1'b0;
      check("t2_fifth_ack", ack, 1'b1);
      check("t2_pop_before_ack", (ram_writes > w0), 1'b1);
      wait_empty("t2_drain", 40);
      for (int i = 0; i < 5; i++)
         check($sformatf("t2_ram%0d", i), ram[32 + i], 32'hA0 + i);

      // 3: read-after-write hazard drains first
      write_req(16'h0040, 32'h12345678, 4'hF, 10, cyc, ack);
      read_req(16'h0040, 40, ack);
      check("t3_read_ack", ack, 1'b1);
      check("t3_rd_after_drain", rd_seen_empty, 1'b1);
      check("t3_data", up_data_rd, 32'h12345678);

      // 5: partial byte-lane write
      write_req(16'h0008, 32'hAABBCCDD, 4'b0010, 10, cyc, ack);
      wait_empty("t5_drain", 20);
      check("t5_ram_word2", ram[2], 32'h0000CC02);

      // 4: non-hazard read bypasses queued writes
      latency = 4;
      write_req(16'h0000, 32'h11111111, 4'hF, 10, cyc, ack);
      write_req(16'h0004, 32'h22222222, 4'hF, 10, cyc, ack);
      write_req(16'h0008, 32'h33333333, 4'hF, 10, cyc, ack);
      read_req(16'h0100, 60, ack);
      check("t4_read_ack", ack, 1'b1);
      check("t4_rd_bypassed", rd_seen_empty, 1'b0);
      check("t4_data", up_data_rd, 32'h00000040);
      wait_empty("t4_drain", 60);
      check("t4_ram_word0", ram[0], 32'h11111111);
      check("t4_ram_word2", ram[2], 32'h33333333);

      // 6: reset during M_WRITE discards the queue
      latency = 1;
      hold = 1'b1;
      for (int i = 0; i < 3; i++)
         write_req(16'h00C0 + 16'(4 * i), 32'h5000 + i, 4'hF, 10, cyc, ack);
      check("t6_in_write", mem_wr, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("t6_mem_wr",       mem_wr, 1'b0);
      check("t6_mem_rd",       mem_rd, 1'b0);
      check("t6_mem_address",  mem_address, 16'h0);
      check("t6_up_ready",     up_ready, 1'b0);
      check("t6_up_data_rd",   up_data_rd, 32'h0);
      check("t6_buffer_empty", buffer_empty, 1'b1);
      #4 rst = 1'b0;
      hold = 1'b0;
      wr_before  = ram_writes;
      cyc_before = mem_wr_cycles;
      repeat (20) @(negedge clk);
      check("t6_no_mem_wr", mem_wr_cycles - cyc_before, 0);
      check("t6_no_ram_write", ram_writes - wr_before, 0);
      check("t6_ram_untouched", ram[48], 32'd48);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
